// File: rtl/cordic_pkg.sv
// Shared constants, FSM encoding and output saturation for the CORDIC vectoring cell.
package cordic_pkg;

   localparam int unsigned DATA_W   = 12;
   localparam int unsigned FRAC_W   = 8;
   localparam int unsigned NUM_ITER = 12;
   localparam int unsigned ITER_W   = 4;
   localparam int unsigned GUARD_W  = 2;
   localparam int unsigned INT_W    = DATA_W + GUARD_W;
   localparam int unsigned MAG_MAX  = (1 << (DATA_W - 1)) - 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PRE  = 2'd1,
      ITER = 2'd2,
      DONE = 2'd3
   } state_e;

   // Clamp the guard-extended x to the non-negative DATA_W range.
   function automatic logic [DATA_W-1:0] saturate(input logic signed [INT_W-1:0] v);
      logic [DATA_W-1:0] r;
      if (v[INT_W-1]) begin
         r = '0;
      end else if (v > $signed(INT_W'(MAG_MAX))) begin
         r = DATA_W'(MAG_MAX);
      end else begin
         r = v[DATA_W-1:0];
      end
      return r;
   endfunction

endpackage

// File: rtl/cordic_vec_stage.sv
// One combinational CORDIC vectoring micro-rotation: steers y toward zero by 2^-k.
module cordic_vec_stage
   import cordic_pkg::*;
(
   input  logic signed [INT_W-1:0]  i_x,
   input  logic signed [INT_W-1:0]  i_y,
   input  logic        [ITER_W-1:0] i_k,
   output logic signed [INT_W-1:0]  o_x,
   output logic signed [INT_W-1:0]  o_y,
   output logic                     o_dir
);

   logic signed [INT_W-1:0] x_sh;
   logic signed [INT_W-1:0] y_sh;

   always_comb begin
      x_sh  = i_x >>> i_k;
      y_sh  = i_y >>> i_k;
      o_dir = ~i_y[INT_W-1];
      if (o_dir) begin
         o_x = i_x + y_sh;
         o_y = i_y - x_sh;
      end else begin
         o_x = i_x - y_sh;
         o_y = i_y + x_sh;
      end
   end

endmodule

// File: rtl/cordic_vector_cell.sv
// QR-array boundary cell: CORDIC vectoring of one complex sample, streaming one
// direction bit per rotation to the row and reporting the (gain-scaled) magnitude.
module cordic_vector_cell
   import cordic_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_trig,
   input  logic [DATA_W-1:0] i_real,
   input  logic [DATA_W-1:0] i_imag,
   output logic              o_busy,
   output logic              o_mode,
   output logic              o_mode_valid,
   output logic [ITER_W-1:0] o_iter,
   output logic [DATA_W-1:0] o_mag,
   output logic              o_finish
);

   state_e                  state_q, state_d;
   logic signed [INT_W-1:0] x_q, x_d;
   logic signed [INT_W-1:0] y_q, y_d;
   logic [ITER_W-1:0]       cnt_q, cnt_d;
   logic                    busy_q, busy_d;
   logic                    mode_q, mode_d;
   logic                    mode_valid_q, mode_valid_d;
   logic [ITER_W-1:0]       iter_q, iter_d;
   logic [DATA_W-1:0]       mag_q, mag_d;
   logic                    finish_q, finish_d;

   logic signed [INT_W-1:0] x_ld;
   logic signed [INT_W-1:0] y_ld;
   logic signed [INT_W-1:0] stage_x;
   logic signed [INT_W-1:0] stage_y;
   logic                    stage_dir;

   cordic_vec_stage u_stage (
      .i_x   (x_q),
      .i_y   (y_q),
      .i_k   (cnt_q),
      .o_x   (stage_x),
      .o_y   (stage_y),
      .o_dir (stage_dir)
   );

   // Outputs are registered one cycle ahead of the state they describe: the
   // 180-degree flip is folded into the load so PRE only has to present its bit.
   always_comb begin
      state_d      = state_q;
      x_d          = x_q;
      y_d          = y_q;
      cnt_d        = cnt_q;
      busy_d       = busy_q;
      mode_d       = 1'b0;
      mode_valid_d = 1'b0;
      iter_d       = '0;
      mag_d        = mag_q;
      finish_d     = 1'b0;
      x_ld         = {{GUARD_W{i_real[DATA_W-1]}}, i_real};
      y_ld         = {{GUARD_W{i_imag[DATA_W-1]}}, i_imag};

      case (state_q)
         IDLE: begin
            if (i_trig) begin
               state_d      = PRE;
               x_d          = i_real[DATA_W-1] ? -x_ld : x_ld;
               y_d          = i_real[DATA_W-1] ? -y_ld : y_ld;
               cnt_d        = '0;
               busy_d       = 1'b1;
               mode_d       = i_real[DATA_W-1];
               mode_valid_d = 1'b1;
            end
         end
         PRE, ITER: begin
            if (cnt_q == ITER_W'(NUM_ITER)) begin
               state_d  = DONE;
               busy_d   = 1'b0;
               finish_d = 1'b1;
               mag_d    = saturate(x_q);
            end else begin
               state_d      = ITER;
               x_d          = stage_x;
               y_d          = stage_y;
               cnt_d        = cnt_q + ITER_W'(1);
               mode_d       = stage_dir;
               mode_valid_d = 1'b1;
               iter_d       = cnt_q + ITER_W'(1);
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= IDLE;
         x_q          <= '0;
         y_q          <= '0;
         cnt_q        <= '0;
         busy_q       <= 1'b0;
         mode_q       <= 1'b0;
         mode_valid_q <= 1'b0;
         iter_q       <= '0;
         mag_q        <= '0;
         finish_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         x_q          <= x_d;
         y_q          <= y_d;
         cnt_q        <= cnt_d;
         busy_q       <= busy_d;
         mode_q       <= mode_d;
         mode_valid_q <= mode_valid_d;
         iter_q       <= iter_d;
         mag_q        <= mag_d;
         finish_q     <= finish_d;
      end
   end

   assign o_busy       = busy_q;
   assign o_mode       = mode_q;
   assign o_mode_valid = mode_valid_q;
   assign o_iter       = iter_q;
   assign o_mag        = mag_q;
   assign o_finish     = finish_q;

endmodule

// File: tb/tb_cordic_vector_cell.sv
// Bench for cordic_vector_cell: directed and random samples against an integer CORDIC model.
module tb_cordic_vector_cell;

   localparam int unsigned DW = 12;
   localparam int unsigned IW = 4;
   localparam int unsigned NI = 12;

   logic          clk;
   logic          rst;
   logic          trig;
   logic [DW-1:0] re_in;
   logic [DW-1:0] im_in;
   logic          busy;
   logic          mode;
   logic          mode_valid;
   logic [IW-1:0] iter;
   logic [DW-1:0] mag;
   logic          finish;

   int n_checks;
   int n_errors;

   cordic_vector_cell dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_trig       (trig),
      .i_real       (re_in),
      .i_imag       (im_in),
      .o_busy       (busy),
      .o_mode       (mode),
      .o_mode_valid (mode_valid),
      .o_iter       (iter),
      .o_mag        (mag),
      .o_finish     (finish)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_errors++;
         $display("FAIL %s got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: flip into the right half-plane, then NUM_ITER shift-add rotations on plain ints.
   task automatic model(input int re, input int im, output logic [NI:0] bits, output int m);
      int x;
      int y;
      int xs;
      int ys;
      x = re;
      y = im;
      bits[0] = (x < 0);
      if (x < 0) begin
         x = -x;
         y = -y;
      end
      for (int k = 0; k < int'(NI); k++) begin
         xs = x >>> k;
         ys = y >>> k;
         bits[k+1] = (y >= 0);
         if (y >= 0) begin
            x = x + ys;
            y = y - xs;
         end else begin
            x = x - ys;
            y = y + xs;
         end
      end
      m = (x < 0) ? 0 : (x > 2047) ? 2047 : x;
   endtask

   task automatic check_idle_zero(input string tag);
      check({tag, "_valid"}, int'(mode_valid), 0);
      check({tag, "_mode"}, int'(mode), 0);
      check({tag, "_iter"}, int'(iter), 0);
      check({tag, "_busy"}, int'(busy), 0);
      check({tag, "_finish"}, int'(finish), 0);
      check({tag, "_mag"}, int'(mag), 0);
   endtask

   // Trig in cycle T, then observe T+1..T+14 at falling edges.
   task automatic run_vec(input int re, input int im, input int trig_again, input int rst_at);
      logic [NI:0] eb;
      int          em;
      model(re, im, eb, em);
      @(negedge clk);
      trig  = 1'b1;
      re_in = DW'(re);
      im_in = DW'(im);
      for (int j = 1; j <= int'(NI) + 2; j++) begin
         @(negedge clk);
         trig  = (j == trig_again);
         re_in = DW'($urandom);
         im_in = DW'($urandom);
         if (j <= int'(NI) + 1) begin
            check($sformatf("valid_%0d_%0d_c%0d", re, im, j), int'(mode_valid), 1);
            check($sformatf("iter_%0d_%0d_c%0d", re, im, j), int'(iter), j - 1);
            check($sformatf("mode_%0d_%0d_c%0d", re, im, j), int'(mode), int'(eb[j-1]));
            check($sformatf("busy_%0d_%0d_c%0d", re, im, j), int'(busy), 1);
            check($sformatf("finish_%0d_%0d_c%0d", re, im, j), int'(finish), 0);
         end else begin
            check($sformatf("valid_end_%0d_%0d", re, im), int'(mode_valid), 0);
            check($sformatf("mode_end_%0d_%0d", re, im), int'(mode), 0);
            check($sformatf("iter_end_%0d_%0d", re, im), int'(iter), 0);
            check($sformatf("busy_end_%0d_%0d", re, im), int'(busy), 0);
            check($sformatf("finish_%0d_%0d", re, im), int'(finish), 1);
            check($sformatf("mag_%0d_%0d", re, im), int'(mag), em);
         end
         trig = trig & (j != int'(NI) + 2);
         if (j == rst_at) begin
            rst  = 1'b1;
            trig = 1'b0;
            @(negedge clk);
            check_idle_zero("abort");
            rst = 1'b0;
            return;
         end
      end
   endtask

   initial begin
      n_checks = 0;
      n_errors = 0;
      rst      = 1'b1;
      trig     = 1'b0;
      re_in    = '0;
      im_in    = '0;
      repeat (3) @(negedge clk);
      check_idle_zero("reset");
      rst = 1'b0;

      run_vec(256, 0, 0, 0);
      run_vec(-256, 0, 0, 0);
      run_vec(0, 256, 0, 0);
      run_vec(0, -256, 0, 0);
      run_vec(2047, 2047, 0, 0);
      run_vec(-2048, -2048, 0, 0);
      run_vec(-2048, 0, 0, 0);
      run_vec(0, 0, 0, 0);
      run_vec(300, -700, 5, 0);
      run_vec(-1000, 512, 0, 6);
      run_vec(-1000, 512, 0, 0);

      for (int n = 0; n < 40; n++) begin
         run_vec(int'($urandom_range(0, 4095)) - 2048,
                 int'($urandom_range(0, 4095)) - 2048,
                 (n % 7 == 3) ? int'($urandom_range(2, 12)) : 0, 0);
      end

      // Idle cycles must keep the stream quiet.
      repeat (4) begin
         @(negedge clk);
         check("idle_valid", int'(mode_valid), 0);
         check("idle_busy", int'(busy), 0);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
